// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the fetch/loader requesters, the arbiter and the shared RAM.
// master = requester/RAM side, slave = arbiter side.
interface ram_port_arbiter_if #(
  parameter int RAM_WIDTH = 22,
  parameter int ADDR_SIZE = 11
);
  logic                 a_req;
  logic [ADDR_SIZE-1:0] a_addr;
  logic                 a_gnt;
  logic                 a_rvalid;
  logic [RAM_WIDTH-1:0] a_rdata;

  logic                 b_req;
  logic                 b_we;
  logic                 b_lock;
  logic [ADDR_SIZE-1:0] b_addr;
  logic [RAM_WIDTH-1:0] b_wdata;
  logic                 b_gnt;
  logic                 b_rvalid;
  logic [RAM_WIDTH-1:0] b_rdata;

  logic                 ram_wr_enb;
  logic                 ram_rd_enb;
  logic [ADDR_SIZE-1:0] ram_addr;
  logic [RAM_WIDTH-1:0] ram_data_in;
  logic [RAM_WIDTH-1:0] ram_data_out;

  modport slave (
    input  a_req, a_addr, b_req, b_we, b_lock, b_addr, b_wdata, ram_data_out,
    output a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
           ram_wr_enb, ram_rd_enb, ram_addr, ram_data_in
  );

  modport master (
    output a_req, a_addr, b_req, b_we, b_lock, b_addr, b_wdata, ram_data_out,
    input  a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
           ram_wr_enb, ram_rd_enb, ram_addr, ram_data_in
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between a read-only fetch
// port (A) and a read/write loader port (B) that can lock the RAM for bursts.
module ram_port_arbiter #(
  parameter int RAM_WIDTH = 22,
  parameter int ADDR_SIZE = 11
) (
  input  logic                clk,
  input  logic                rst,
  ram_port_arbiter_if.slave   bus,
  output logic                locked
);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_last_b;
  logic                 r_rvalid;
  logic                 r_tag_b;
  logic [ADDR_SIZE-1:0] r_addr;
  logic [RAM_WIDTH-1:0] r_wdata;

  logic w_a_gnt, w_b_gnt, w_wr, w_rd;

  // Grant selection and next state; while LOCKED only B competes, including
  // the cycle in which b_lock drops.
  always_comb begin
    w_a_gnt     = 1'b0;
    w_b_gnt     = 1'b0;
    w_state_nxt = r_state;
    if (!rst) begin
      case (r_state)
        ARB: begin
          w_a_gnt = bus.a_req && (!bus.b_req || r_last_b);
          w_b_gnt = bus.b_req && (!bus.a_req || !r_last_b);
          if (w_b_gnt && bus.b_lock) w_state_nxt = LOCKED;
        end
        LOCKED: begin
          w_b_gnt = bus.b_req;
          if (!bus.b_lock) w_state_nxt = ARB;
        end
        default: w_state_nxt = ARB;
      endcase
    end
  end

  assign w_wr = w_b_gnt && bus.b_we;
  assign w_rd = w_a_gnt || (w_b_gnt && !bus.b_we);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ARB;
      r_last_b <= 1'b1;
      r_rvalid <= 1'b0;
      r_tag_b  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rvalid <= w_rd;
      r_tag_b  <= w_b_gnt;
      if (w_a_gnt || w_b_gnt) r_last_b <= w_b_gnt;
    end
  end

  // Address/data hold their last driven value on idle cycles.
  always_ff @(posedge clk) begin
    if (w_a_gnt || w_b_gnt) r_addr <= w_a_gnt ? bus.a_addr : bus.b_addr;
    if (w_wr) r_wdata <= bus.b_wdata;
  end

  assign bus.a_gnt       = w_a_gnt;
  assign bus.b_gnt       = w_b_gnt;
  assign bus.ram_wr_enb  = w_wr;
  assign bus.ram_rd_enb  = w_rd;
  assign bus.ram_addr    = w_a_gnt ? bus.a_addr : (w_b_gnt ? bus.b_addr : r_addr);
  assign bus.ram_data_in = w_wr ? bus.b_wdata : r_wdata;

  // A response in flight when reset is asserted is discarded immediately.
  assign bus.a_rvalid = r_rvalid && !r_tag_b && !rst;
  assign bus.b_rvalid = r_rvalid &&  r_tag_b && !rst;
  assign bus.a_rdata  = bus.ram_data_out;
  assign bus.b_rdata  = bus.ram_data_out;
  assign locked       = (r_state == LOCKED);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural single-port RAM.
module tb_ram_port_arbiter;
  localparam int RW = 22;
  localparam int AW = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic locked;
  int   ncmp = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  ram_port_arbiter_if #(.RAM_WIDTH(RW), .ADDR_SIZE(AW)) bus ();

  ram_port_arbiter #(.RAM_WIDTH(RW), .ADDR_SIZE(AW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus.slave),
    .locked (locked)
  );

  // RAM model: unwritten words return fixed preload contents.
  logic [RW-1:0] mem [2**AW];
  logic          written [2**AW];

  function automatic logic [RW-1:0] preload(input logic [AW-1:0] a);
    case (a)
      11'd3:   return 22'h200600;
      11'd10:  return 22'h012345;
      11'd200: return 22'h03ABCD;
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (bus.ram_wr_enb) begin
      mem[bus.ram_addr]     <= bus.ram_data_in;
      written[bus.ram_addr] <= 1'b1;
    end
    if (bus.ram_rd_enb)
      bus.ram_data_out <= (written[bus.ram_addr] === 1'b1) ? mem[bus.ram_addr]
                                                            : preload(bus.ram_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.a_req = 0; bus.a_addr = '0;
    bus.b_req = 0; bus.b_we = 0; bus.b_lock = 0; bus.b_addr = '0; bus.b_wdata = '0;
    #1;
    // Reset: requests present but nothing granted
    bus.a_req = 1; bus.b_req = 1;
    @(negedge clk);
    chk("rst_a_gnt", bus.a_gnt, 0);
    chk("rst_b_gnt", bus.b_gnt, 0);
    chk("rst_rd", bus.ram_rd_enb, 0);
    chk("rst_wr", bus.ram_wr_enb, 0);
    nxt();
    @(negedge clk);
    chk("rst_a_rv", bus.a_rvalid, 0);
    chk("rst_b_rv", bus.b_rvalid, 0);
    chk("rst_locked", locked, 0);
    nxt();

    // Single A read
    rst = 0; bus.b_req = 0; bus.a_req = 1; bus.a_addr = 11'd3;
    @(negedge clk);
    chk("t1_a_gnt", bus.a_gnt, 1);
    chk("t1_rd", bus.ram_rd_enb, 1);
    chk("t1_addr", bus.ram_addr, 3);
    nxt();
    bus.a_req = 0;
    @(negedge clk);
    chk("t1_a_rv", bus.a_rvalid, 1);
    chk("t1_a_rdata", bus.a_rdata, 22'h200600);
    chk("t1_b_rv", bus.b_rvalid, 0);
    chk("t1_idle_rd", bus.ram_rd_enb, 0);
    chk("t1_idle_addr", bus.ram_addr, 3);
    nxt();

    // Contention after a fresh reset: A, B, A, B
    rst = 1;
    nxt();
    rst = 0;
    bus.a_req = 1; bus.a_addr = 11'd10;
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 11'd200;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2_a_gnt", bus.a_gnt, (k % 2 == 0));
      chk("t2_b_gnt", bus.b_gnt, (k % 2 == 1));
      chk("t2_rd", bus.ram_rd_enb, 1);
      if (k > 0) begin
        chk("t2_a_rv", bus.a_rvalid, ((k - 1) % 2 == 0));
        chk("t2_b_rv", bus.b_rvalid, ((k - 1) % 2 == 1));
        chk("t2_rdata", bus.a_rdata, ((k - 1) % 2 == 0) ? 22'h012345 : 22'h03ABCD);
      end
      nxt();
    end
    bus.a_req = 0; bus.b_req = 0;
    @(negedge clk);
    chk("t2_last_b_rv", bus.b_rvalid, 1);
    chk("t2_last_a_rv", bus.a_rvalid, 0);
    chk("t2_last_rdata", bus.b_rdata, 22'h03ABCD);
    nxt();

    // B write then B read of same address
    bus.b_req = 1; bus.b_we = 1; bus.b_addr = 11'd12; bus.b_wdata = 22'h0A5A5A;
    @(negedge clk);
    chk("t3_b_gnt", bus.b_gnt, 1);
    chk("t3_wr", bus.ram_wr_enb, 1);
    chk("t3_wr_rd", bus.ram_rd_enb, 0);
    chk("t3_addr", bus.ram_addr, 12);
    chk("t3_din", bus.ram_data_in, 22'h0A5A5A);
    nxt();
    bus.b_we = 0;
    @(negedge clk);
    chk("t3_rd", bus.ram_rd_enb, 1);
    chk("t3_rd_wr", bus.ram_wr_enb, 0);
    chk("t3_no_rv_wr", bus.b_rvalid, 0);
    nxt();
    bus.b_req = 0;
    @(negedge clk);
    chk("t3_b_rv", bus.b_rvalid, 1);
    chk("t3_b_rdata", bus.b_rdata, 22'h0A5A5A);
    nxt();

    // A read so that B wins the next contention
    bus.a_req = 1; bus.a_addr = 11'd5;
    @(negedge clk);
    chk("t4_pre_a_gnt", bus.a_gnt, 1);
    nxt();

    // Locked burst of B writes with A waiting
    bus.b_req = 1; bus.b_we = 1; bus.b_lock = 1;
    for (int c = 1; c <= 5; c++) begin
      bus.b_addr = 11'(c - 1); bus.b_wdata = 22'h100000 | 22'(c - 1);
      @(negedge clk);
      chk("t4_b_gnt", bus.b_gnt, 1);
      chk("t4_a_gnt", bus.a_gnt, 0);
      chk("t4_wr", bus.ram_wr_enb, 1);
      chk("t4_locked", locked, (c >= 2));
      nxt();
    end
    bus.b_req = 0; bus.b_we = 0; bus.b_lock = 0;
    @(negedge clk);
    chk("t4_c6_a_gnt", bus.a_gnt, 0);
    chk("t4_c6_locked", locked, 1);
    nxt();
    @(negedge clk);
    chk("t4_c7_locked", locked, 0);
    chk("t4_c7_a_gnt", bus.a_gnt, 1);
    nxt();
    bus.a_req = 0;
    bus.b_req = 1; bus.b_addr = 11'd2;
    @(negedge clk);
    chk("t4_a_rv", bus.a_rvalid, 1);
    chk("t4_a_rdata", bus.a_rdata, 22'h000000);
    chk("t4_rb_gnt", bus.b_gnt, 1);
    nxt();
    bus.b_req = 0;
    @(negedge clk);
    chk("t4_rb_rv", bus.b_rvalid, 1);
    chk("t4_rb_rdata", bus.b_rdata, 22'h100002);
    nxt();

    // Reset in the cycle after an A grant
    bus.a_req = 1; bus.a_addr = 11'd3;
    @(negedge clk);
    chk("t5_a_gnt", bus.a_gnt, 1);
    nxt();
    rst = 1; bus.b_req = 1; bus.b_we = 0; bus.b_addr = 11'd200;
    @(negedge clk);
    chk("t5_a_rv", bus.a_rvalid, 0);
    chk("t5_rd", bus.ram_rd_enb, 0);
    chk("t5_wr", bus.ram_wr_enb, 0);
    chk("t5_gnt", {bus.a_gnt, bus.b_gnt}, 0);
    nxt();
    rst = 0;
    @(negedge clk);
    chk("t5_a_rv_post", bus.a_rvalid, 0);
    chk("t5_first_a", bus.a_gnt, 1);
    chk("t5_first_b", bus.b_gnt, 0);
    nxt();
    @(negedge clk);
    chk("t5_second_b", bus.b_gnt, 1);
    nxt();
    bus.a_req = 0; bus.b_req = 0;
    nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port 22-bit instruction/data RAM between two requesters.
- Port A is the CPU fetch path and is read-only. Port B is the loader/debug path and can read and write.
- Issues at most one RAM access per cycle, round-robin between A and B. Port B can lock the RAM for burst program loading.
- Sits between the CPU fetch unit/loader and the RAM's clk/wr_enb/rd_enb/addr/data_in/data_out interface.

Parameters:
- RAM_WIDTH, 22: RAM word width (14 + 8).
- ADDR_SIZE, 11: RAM address width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset, sampled on rising edge of clk.
- a_req  in  1  port A read request; held until a_gnt.
- a_addr  in  ADDR_SIZE  port A read address.
- a_gnt  out  1  port A request issued to RAM this cycle (combinational).
- a_rvalid  out  1  port A read data valid (registered).
- a_rdata  out  RAM_WIDTH  port A read data.
- b_req  in  1  port B request; held until b_gnt.
- b_we  in  1  port B request is a write (1) or read (0).
- b_lock  in  1  port B requests exclusive RAM ownership.
- b_addr  in  ADDR_SIZE  port B address.
- b_wdata  in  RAM_WIDTH  port B write data.
- b_gnt  out  1  port B request issued this cycle (combinational).
- b_rvalid  out  1  port B read data valid (registered; never set for writes).
- b_rdata  out  RAM_WIDTH  port B read data.
- locked  out  1  arbiter is in LOCKED state.
- ram_wr_enb  out  1  to RAM wr_enb.
- ram_rd_enb  out  1  to RAM rd_enb.
- ram_addr  out  ADDR_SIZE  to RAM addr.
- ram_data_in  out  RAM_WIDTH  to RAM data_in.
- ram_data_out  in  RAM_WIDTH  from RAM data_out; registered, valid 1 cycle after rd_enb.

Behaviour:
- Reset: a_rvalid = b_rvalid = 0, locked = 0, state ARB, last_grant = B (so A wins the first contention).
  - A pending read response is discarded. a_rdata/b_rdata are don't-care while rvalid = 0.
  - While rst = 1, a_gnt, b_gnt, ram_wr_enb and ram_rd_enb are 0.
- Grant (combinational, same cycle as request):
  - State ARB, only one req high: that port is granted.
  - State ARB, both high: the port not equal to last_grant is granted; last_grant updates on each grant.
  - State LOCKED: only B can be granted; a_gnt = 0 regardless of a_req.
- RAM drive:
  - Granted A: rd_enb = 1, addr = a_addr.
  - Granted B read: rd_enb = 1, addr = b_addr.
  - Granted B write: wr_enb = 1, addr = b_addr, data_in = b_wdata.
  - No grant: both enables 0; addr/data_in hold last driven values.
  - wr_enb and rd_enb are never 1 in the same cycle.
- Read latency: grant at cycle N -> that port's rvalid = 1 in cycle N+1 only, rdata = ram_data_out (passthrough).
  - A one-bit response tag register, set at the grant edge, selects which port sees rvalid.
  - Back-to-back grants give rvalid on consecutive cycles.
- Write followed by read of the same address in the next cycle returns the new data.
- FSM:
  - ARB -> LOCKED when B is granted with b_lock = 1. locked = 1 from the next cycle.
  - LOCKED -> ARB on the first cycle b_lock = 0. B may be granted in that cycle; A is eligible from the next cycle.
  - While LOCKED, a_req stays pending with no timeout.
- Protocol: requesters hold req/addr/we/wdata stable until gnt. Dropping req before gnt is permitted and cancels the request.

Test Plan:
- Reset then a_req = 1, a_addr = 3, with RAM preloaded mem[3] = 22'h200600 -> a_gnt = 1 in the same cycle, ram_rd_enb = 1, ram_addr = 3; next cycle a_rvalid = 1, a_rdata = 22'h200600, b_rvalid = 0.
- Both req held for 4 cycles (A addr 10, B read addr 200) after reset -> grant order A, B, A, B; rvalid alternates a, b, a, b one cycle later; never two grants in one cycle.
- B write addr 12 data 22'h0A5A5A, then B read addr 12 next cycle -> ram_wr_enb cycle 1, ram_rd_enb cycle 2; b_rvalid in cycle 3 with 22'h0A5A5A; b_rvalid never set for the write.
- B write with b_lock = 1 for 5 cycles to addrs 0..4 while a_req = 1 -> locked = 1 from cycle 2; a_gnt = 0 throughout. b_lock drops in cycle 6 -> locked = 0 in cycle 7; a_gnt = 1 in cycle 7.
- rst asserted in the cycle after an A grant -> a_rvalid stays 0, all enables 0. After release, the first contention grants A.
- Random req/we/lock traffic vs. reference model, 10k cycles -> every read returns the model's memory contents; grant count per port differs by ≤1 under continuous contention when unlocked.
